// File: rtl/biu_arbiter_pkg.sv
// ============================================================================
// biu_arbiter_pkg : shared types and constants for the BIU read arbiter
// Revision 1.0
// ============================================================================
`default_nettype none

package biu_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int BIU_DW     = 32;
  localparam int BYTE_SHIFT = 2;

endpackage

`default_nettype wire

// File: rtl/biu_arbiter_if.sv
// ============================================================================
// biu_arbiter_if : requester-side BIU request/response bus bundle
// Revision 1.0
// ============================================================================
`default_nettype none

interface biu_arbiter_if #(
  parameter int NUM_CLI = 3
);
  import biu_arbiter_pkg::*;

  logic [NUM_CLI-1:0]             cli_req;
  logic [NUM_CLI-1:0][BIU_DW-1:0] cli_addr;
  logic [NUM_CLI-1:0]             cli_vld;
  logic [NUM_CLI-1:0]             cli_rdy;
  logic [BIU_DW-1:0]              cli_rsp_data;
  logic [NUM_CLI-1:0]             cli_rsp_vld;
  logic [NUM_CLI-1:0]             cli_rsp_rdy;

  modport slave (
    input  cli_req, cli_addr, cli_vld, cli_rsp_rdy,
    output cli_rdy, cli_rsp_data, cli_rsp_vld
  );

  modport master (
    output cli_req, cli_addr, cli_vld, cli_rsp_rdy,
    input  cli_rdy, cli_rsp_data, cli_rsp_vld
  );

endinterface

`default_nettype wire

// File: rtl/biu_rsp_fifo.sv
// ============================================================================
// biu_rsp_fifo : synchronous response FIFO, power-of-two depth, async reset
// Revision 1.0
// ============================================================================
`default_nettype none

module biu_rsp_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr_ptr] <= wdata;
  end

  assign rdata = r_mem[r_rd_ptr];
  assign full  = (r_count == CW'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule

`default_nettype wire

// File: rtl/biu_arbiter.sv
// ============================================================================
// biu_arbiter : round-robin burst arbiter of BIU readers onto one memory port
// Revision 1.0
// ============================================================================
`default_nettype none

module biu_arbiter
  import biu_arbiter_pkg::*;
#(
  parameter int NUM_CLI   = 3,
  parameter int MEM_AW    = 14,
  parameter int RD_LAT    = 2,
  parameter int RSP_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  biu_arbiter_if.slave      bus,
  output logic              mem_en,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [BIU_DW-1:0] mem_rdata
);

  localparam int IW  = (NUM_CLI > 1) ? $clog2(NUM_CLI) : 1;
  localparam int FCW = $clog2(RSP_DEPTH) + 1;
  localparam int CRW = FCW + 1;

  state_e             r_state;
  state_e             w_state_nxt;
  logic [IW-1:0]      r_owner;
  logic [IW-1:0]      r_rr_ptr;
  logic [IW-1:0]      w_pick;
  logic [IW-1:0]      w_idx;
  logic [IW-1:0]      w_owner_inc;
  logic               w_any_req;
  logic [RD_LAT-1:0]  r_lat;
  logic [RD_LAT-1:0]  w_lat_nxt;
  logic [CRW-1:0]     w_inflight;
  logic [CRW-1:0]     w_credit_used;
  logic               w_credit_ok;
  logic               w_issue;
  logic               w_push;
  logic               w_pop;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic [FCW-1:0]     w_fifo_cnt;
  logic [BIU_DW-1:0]  w_fifo_rdata;
  logic [NUM_CLI-1:0] w_rdy;
  logic [NUM_CLI-1:0] w_rsp_vld;
  logic               w_unused_addr;

  assign w_any_req = |bus.cli_req;

  // Descending scan so the requester closest at/after rr_ptr wins last.
  always_comb begin
    w_pick = r_rr_ptr;
    w_idx  = '0;
    for (int k = NUM_CLI - 1; k >= 0; k--) begin
      w_idx = IW'((int'(r_rr_ptr) + k) % NUM_CLI);
      if (bus.cli_req[w_idx]) w_pick = w_idx;
    end
  end

  assign w_owner_inc = (r_owner == IW'(NUM_CLI - 1)) ? '0 : r_owner + IW'(1);

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      w_inflight = w_inflight + CRW'(r_lat[i]);
    end
  end

  // Credit covers words already issued but not yet popped, so the FIFO never overflows.
  assign w_credit_used = w_inflight + CRW'(w_fifo_cnt);
  assign w_credit_ok   = (w_credit_used < CRW'(RSP_DEPTH));

  always_comb begin
    w_state_nxt = r_state;
    w_rdy       = '0;
    w_issue     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) w_state_nxt = ST_GRANT;
      end
      ST_GRANT: begin
        w_rdy[r_owner] = w_credit_ok;
        w_issue        = bus.cli_vld[r_owner] & w_credit_ok;
        if (!bus.cli_req[r_owner]) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if ((w_inflight == '0) && w_fifo_empty) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  generate
    if (RD_LAT == 1) begin : g_lat_single
      assign w_lat_nxt = w_issue;
    end else begin : g_lat_shift
      assign w_lat_nxt = {r_lat[RD_LAT-2:0], w_issue};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_owner  <= '0;
      r_rr_ptr <= '0;
      r_lat    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_lat   <= w_lat_nxt;
      if ((r_state == ST_IDLE) && w_any_req) r_owner <= w_pick;
      if ((r_state == ST_DRAIN) && (w_state_nxt == ST_IDLE)) r_rr_ptr <= w_owner_inc;
    end
  end

  assign w_push = r_lat[RD_LAT-1];

  always_comb begin
    w_rsp_vld          = '0;
    w_rsp_vld[r_owner] = ~w_fifo_empty;
  end

  assign w_pop = |(w_rsp_vld & bus.cli_rsp_rdy);

  biu_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (BIU_DW)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .wdata (mem_rdata),
    .pop   (w_pop),
    .rdata (w_fifo_rdata),
    .full  (w_fifo_full),
    .empty (w_fifo_empty),
    .count (w_fifo_cnt)
  );

  assign mem_en   = w_issue;
  assign mem_addr = w_issue ? bus.cli_addr[r_owner][MEM_AW+BYTE_SHIFT-1:BYTE_SHIFT] : '0;

  assign bus.cli_rdy      = w_rdy;
  assign bus.cli_rsp_vld  = w_rsp_vld;
  assign bus.cli_rsp_data = w_fifo_empty ? '0 : w_fifo_rdata;

  assign w_unused_addr = ^{bus.cli_addr, w_fifo_full};

endmodule

`default_nettype wire

// File: tb/tb_biu_arbiter.sv
// ============================================================================
// tb_biu_arbiter : randomized bench with a queue-based reference model
// Revision 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_biu_arbiter;

  localparam int NUM_CLI   = 3;
  localparam int MEM_AW    = 14;
  localparam int RD_LAT    = 2;
  localparam int RSP_DEPTH = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              mem_en;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_rdata;

  biu_arbiter_if #(.NUM_CLI(NUM_CLI)) bus ();

  biu_arbiter #(
    .NUM_CLI   (NUM_CLI),
    .MEM_AW    (MEM_AW),
    .RD_LAT    (RD_LAT),
    .RSP_DEPTH (RSP_DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] memval(input logic [MEM_AW-1:0] a);
    return 32'(a) * 32'h9E37_79B1 + 32'h0BAD_F00D;
  endfunction

  // Memory: data for a strobe in cycle T is presented during cycle T+RD_LAT.
  logic [31:0] pipe [RD_LAT];
  always @(posedge clk) begin
    pipe[0] <= mem_en ? memval(mem_addr) : 32'hDEAD_BEEF;
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata = pipe[RD_LAT-1];

  // Requester state
  int          total  [NUM_CLI];
  int          acc_n  [NUM_CLI];
  int          rcv_n  [NUM_CLI];
  logic [31:0] next_addr [NUM_CLI];
  bit          active [NUM_CLI];
  bit          early  [NUM_CLI];
  bit          vrand  [NUM_CLI];
  int          rmode  [NUM_CLI];
  bit          acc_ev [NUM_CLI];
  bit          pop_ev [NUM_CLI];

  task automatic start(input int c, input int n, input logic [31:0] base,
                       input int rm, input bit vr, input bit er);
    total[c] = n; acc_n[c] = 0; rcv_n[c] = 0; next_addr[c] = base;
    rmode[c] = rm; vrand[c] = vr; early[c] = er; active[c] = 1'b1;
  endtask

  initial begin
    for (int c = 0; c < NUM_CLI; c++) begin
      total[c] = 0; acc_n[c] = 0; rcv_n[c] = 0; next_addr[c] = '0;
      active[c] = 0; early[c] = 0; vrand[c] = 0; rmode[c] = 0;
      acc_ev[c] = 0; pop_ev[c] = 0;
    end
    bus.cli_req = '0; bus.cli_vld = '0; bus.cli_addr = '0; bus.cli_rsp_rdy = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int c = 0; c < NUM_CLI; c++) begin
        if (acc_ev[c]) begin acc_n[c]++; next_addr[c] += 32'd4; end
        if (pop_ev[c]) rcv_n[c]++;
        acc_ev[c] = 1'b0;
        pop_ev[c] = 1'b0;
        if (active[c] && (early[c] ? (acc_n[c] >= total[c]) : (rcv_n[c] >= total[c])))
          active[c] = 1'b0;
        bus.cli_req[c]  = active[c];
        bus.cli_vld[c]  = active[c] && (acc_n[c] < total[c]) &&
                          (!vrand[c] || ($urandom_range(3) != 0));
        bus.cli_addr[c] = next_addr[c];
        case (rmode[c])
          0:       bus.cli_rsp_rdy[c] = 1'b1;
          1:       bus.cli_rsp_rdy[c] = 1'($urandom_range(1));
          default: bus.cli_rsp_rdy[c] = 1'b0;
        endcase
      end
    end
  end

  // Reference model: a queue of accepted words, each maturing RD_LAT+1 cycles after accept.
  typedef struct { logic [31:0] d; int rc; } ent_t;
  ent_t mq[$];
  int   cyc = 0;
  int   m_phase = 0;   // 0 idle, 1 granted, 2 draining
  int   m_owner = 0;
  int   m_rr = 0;
  int   glog[$];
  int   last_log = -1;
  bit   t1_on = 0;
  int   t1_req = -1, t1_first = -1, t1_last = -1, t1_nv = 0;

  always @(negedge clk) begin
    logic [NUM_CLI-1:0] e_rdy, e_vld;
    logic [31:0]        e_data;
    logic               e_en;
    logic [MEM_AW-1:0]  e_addr;
    int                 sz0;
    e_rdy = '0; e_vld = '0; e_data = '0; e_en = 1'b0; e_addr = '0;
    sz0 = mq.size();
    if (!rst_n) begin
      mq.delete();
      m_phase = 0; m_owner = 0; m_rr = 0;
    end else begin
      if (m_phase == 1 && sz0 < RSP_DEPTH) e_rdy[m_owner] = 1'b1;
      if (sz0 > 0 && mq[0].rc <= cyc) begin
        e_vld[m_owner] = 1'b1;
        e_data = mq[0].d;
      end
      if (e_rdy[m_owner] && bus.cli_vld[m_owner]) begin
        e_en   = 1'b1;
        e_addr = bus.cli_addr[m_owner][MEM_AW+1:2];
      end
    end
    chk("cli_rdy",      32'(bus.cli_rdy),     32'(e_rdy));
    chk("cli_rsp_vld",  32'(bus.cli_rsp_vld), 32'(e_vld));
    chk("cli_rsp_data", bus.cli_rsp_data,     e_data);
    chk("mem_en",       32'(mem_en),          32'(e_en));
    chk("mem_addr",     32'(mem_addr),        32'(e_addr));
    if (rst_n) begin
      for (int c = 0; c < NUM_CLI; c++) begin
        acc_ev[c] = bus.cli_vld[c] & bus.cli_rdy[c];
        pop_ev[c] = bus.cli_rsp_vld[c] & bus.cli_rsp_rdy[c];
        if (acc_ev[c] && c != last_log) begin glog.push_back(c); last_log = c; end
      end
      if (t1_on) begin
        if (t1_req < 0 && bus.cli_req[1]) t1_req = cyc;
        if (bus.cli_rsp_vld[1]) begin
          if (t1_first < 0) t1_first = cyc;
          t1_last = cyc;
          t1_nv++;
        end
      end
      if (e_en) mq.push_back('{memval(e_addr), cyc + RD_LAT + 1});
      if (e_vld[m_owner] && bus.cli_rsp_rdy[m_owner]) void'(mq.pop_front());
      case (m_phase)
        0: if (|bus.cli_req) begin
             for (int k = NUM_CLI - 1; k >= 0; k--)
               if (bus.cli_req[(m_rr + k) % NUM_CLI]) m_owner = (m_rr + k) % NUM_CLI;
             m_phase = 1;
           end
        1: if (!bus.cli_req[m_owner]) m_phase = 2;
        default: if (sz0 == 0) begin m_phase = 0; m_rr = (m_owner + 1) % NUM_CLI; end
      endcase
    end else begin
      for (int c = 0; c < NUM_CLI; c++) begin acc_ev[c] = 0; pop_ev[c] = 0; end
    end
    cyc++;
  end

  task automatic wait_all(input int budget, input string nm);
    int n;
    bit busy;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      busy = 1'b0;
      for (int c = 0; c < NUM_CLI; c++)
        if (active[c] || rcv_n[c] < total[c]) busy = 1'b1;
    end while (busy && n < budget);
    if (busy) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: timeout after %0d cycles, still busy, required idle", nm, n);
    end
  endtask

  task automatic do_reset(input int hold);
    @(posedge clk); #3;
    rst_n = 1'b0;
    for (int c = 0; c < NUM_CLI; c++) begin
      active[c] = 0; total[c] = 0; acc_n[c] = 0; rcv_n[c] = 0;
    end
    #1;
    chk("rst_rdy",      32'(bus.cli_rdy),     32'h0);
    chk("rst_rsp_vld",  32'(bus.cli_rsp_vld), 32'h0);
    chk("rst_rsp_data", bus.cli_rsp_data,     32'h0);
    chk("rst_mem_en",   32'(mem_en),          32'h0);
    repeat (hold) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, got hang, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    do_reset(2);

    // Single weight-client burst at full rate
    t1_on = 1;
    start(1, 160, 32'h0000_1000, 0, 0, 0);
    wait_all(1000, "t1_burst");
    t1_on = 0;
    chk("t1_rcv_count", 32'(rcv_n[1]),              32'd160);
    chk("t1_latency",   32'(t1_first - t1_req),     32'd4);
    chk("t1_gapless",   32'(t1_last - t1_first + 1), 32'd160);
    chk("t1_vld_count", 32'(t1_nv),                 32'd160);

    // Round-robin ties
    do_reset(2);
    glog.delete(); last_log = -1;
    start(0, 10, 32'h0000_2000, 0, 0, 0);
    start(1, 10, 32'h0000_3000, 0, 0, 0);
    wait_all(500, "t2_tie_a");
    start(0, 6, 32'h0000_4000, 0, 0, 0);
    start(2, 6, 32'h0000_5000, 0, 0, 0);
    wait_all(500, "t2_tie_b");
    chk("t2_log_len", 32'(glog.size()), 32'd4);
    if (glog.size() == 4) begin
      chk("t2_grant0", 32'(glog[0]), 32'd0);
      chk("t2_grant1", 32'(glog[1]), 32'd1);
      chk("t2_grant2", 32'(glog[2]), 32'd2);
      chk("t2_grant3", 32'(glog[3]), 32'd0);
    end

    // Credit limit with response back-pressure
    start(1, 20, 32'h0000_6000, 2, 0, 0);
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk("t3_accepted", 32'(acc_n[1] + 32'(acc_ev[1])), 32'd8);
    chk("t3_rdy_low",  32'(bus.cli_rdy[1]),            32'd0);
    rmode[1] = 0;
    wait_all(500, "t3_release");
    chk("t3_rcv_count", 32'(rcv_n[1]), 32'd20);

    // Random back-pressure around a nearly full FIFO
    start(2, 40, 32'h0000_7000, 1, 1, 0);
    wait_all(1000, "t4_random_rdy");
    chk("t4_rcv_count", 32'(rcv_n[2]), 32'd40);

    // Early request drop with words in flight, then rr advance
    glog.delete(); last_log = -1;
    start(2, 3, 32'h0000_8000, 0, 0, 1);
    wait_all(200, "t5_drain");
    chk("t5_rcv_count", 32'(rcv_n[2]), 32'd3);
    start(0, 4, 32'h0000_9000, 0, 0, 0);
    start(1, 4, 32'h0000_A000, 0, 0, 0);
    wait_all(300, "t5_next");
    chk("t5_log_len", 32'(glog.size()), 32'd3);
    if (glog.size() == 3) begin
      chk("t5_grant0", 32'(glog[0]), 32'd2);
      chk("t5_grant1", 32'(glog[1]), 32'd0);
      chk("t5_grant2", 32'(glog[2]), 32'd1);
    end

    // Reset in the middle of a burst
    start(0, 50, 32'h0000_B000, 0, 0, 0);
    repeat (15) @(posedge clk);
    do_reset(3);
    start(0, 20, 32'h0000_C000, 0, 0, 0);
    wait_all(300, "t6_after_reset");
    chk("t6_rcv_count", 32'(rcv_n[0]), 32'd20);

    // Randomized rounds
    for (int r = 0; r < 10; r++) begin
      int mask;
      mask = int'($urandom_range(1, 7));
      for (int c = 0; c < NUM_CLI; c++) begin
        if (mask[c])
          start(c, int'($urandom_range(1, 30)), $urandom() & 32'hFFFF_FFFC,
                int'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)));
      end
      wait_all(3000, "rand_round");
    end

    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
